// File: rtl/jk_pkg.sv
// Shared encodings for the JK-cell based counters: counter modes and the
// per-cell J/K action codes, plus a helper that picks the action to reach a bit value.
package jk_pkg;

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_UP   = 2'b01;
    localparam logic [1:0] MODE_DOWN = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // J/K action codes, written as {J, K}
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    typedef logic [1:0] jk_act_t;

    // Smallest action that takes a cell from cur to tgt: hold if already there.
    function automatic jk_act_t jkForce(input logic cur, input logic tgt);
        if (cur == tgt) begin
            return JK_HOLD;
        end
        return tgt ? JK_SET : JK_RST;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset to a per-instance value.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    input  logic rst_val,
    output logic q
);

    logic q_q;

    // Classic JK behaviour: hold, reset, set, toggle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= rst_val;
        end else begin
            case ({j, k})
                JK_RST:  q_q <= 1'b0;
                JK_SET:  q_q <= 1'b1;
                JK_TGL:  q_q <= ~q_q;
                default: q_q <= q_q;
            endcase
        end
    end

    assign q = q_q;

endmodule

// File: rtl/jk_mod_counter.sv
// Modulo-N up/down counter with parallel load, built from WIDTH JK cells.
// Counting is done purely with per-bit toggles; wrap and load force bits directly.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 10,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_VEC = WIDTH'(RESET_VAL);

    logic [WIDTH-1:0]      cellQ;
    logic [WIDTH-1:0][1:0] jkAct;
    logic [WIDTH-1:0]      loadData;
    logic                  lowAll;
    logic                  wrap_d;
    logic                  wrap_q;

    assign loadData = (load_val > MAX_VAL) ? MAX_VAL : load_val;

    // Decode the J/K action for every cell. Anything at or past the top of the
    // range while counting up (including illegal states) goes back to zero.
    always_comb begin
        jkAct  = '0;
        wrap_d = 1'b0;
        lowAll = 1'b1;
        if (en) begin
            case (mode)
                MODE_UP: begin
                    if (cellQ >= MAX_VAL) begin
                        wrap_d = 1'b1;
                        for (int i = 0; i < WIDTH; i++) begin
                            jkAct[i] = jkForce(cellQ[i], 1'b0);
                        end
                    end else begin
                        for (int i = 0; i < WIDTH; i++) begin
                            jkAct[i] = lowAll ? JK_TGL : JK_HOLD;
                            lowAll   = lowAll & cellQ[i];
                        end
                    end
                end
                MODE_DOWN: begin
                    if (cellQ > MAX_VAL) begin
                        wrap_d = 1'b1;
                        for (int i = 0; i < WIDTH; i++) begin
                            jkAct[i] = jkForce(cellQ[i], 1'b0);
                        end
                    end else if (cellQ == '0) begin
                        wrap_d = 1'b1;
                        for (int i = 0; i < WIDTH; i++) begin
                            jkAct[i] = jkForce(cellQ[i], MAX_VAL[i]);
                        end
                    end else begin
                        for (int i = 0; i < WIDTH; i++) begin
                            jkAct[i] = lowAll ? JK_TGL : JK_HOLD;
                            lowAll   = lowAll & ~cellQ[i];
                        end
                    end
                end
                MODE_LOAD: begin
                    for (int i = 0; i < WIDTH; i++) begin
                        jkAct[i] = {loadData[i], ~loadData[i]};
                    end
                end
                default: begin
                    jkAct = '0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : gCell
        jk_cell uCell (
            .clk     (clk),
            .rst     (rst),
            .j       (jkAct[g][1]),
            .k       (jkAct[g][0]),
            .rst_val (RST_VEC[g]),
            .q       (cellQ[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign q    = cellQ;
    assign wrap = wrap_q;
    assign tc   = en & (((mode == MODE_UP) & (cellQ == MAX_VAL)) |
                        ((mode == MODE_DOWN) & (cellQ == '0)));

endmodule
